// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer for a single-port ram; RAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module ram_arbiter #(
   parameter int ADDR_BITS   = 16,
   parameter int DATA_BITS   = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDR_BITS-1:0] m0_addr,
   input  logic [DATA_BITS-1:0] m0_wdata,
   output logic [DATA_BITS-1:0] m0_rdata,
   output logic                 m0_done,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDR_BITS-1:0] m1_addr,
   input  logic [DATA_BITS-1:0] m1_wdata,
   output logic [DATA_BITS-1:0] m1_rdata,
   output logic                 m1_done,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic [ADDR_BITS-1:0] ram_address,
   output logic [DATA_BITS-1:0] ram_data_in,
   output logic                 ram_write_enable,
   input  logic [DATA_BITS-1:0] ram_data_out
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic last_cnt;
   logic win;
   logic sel;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic ptr;
   assign win = (m0_req & m1_req) ? ptr : m1_req;
`else
   assign win = ~m0_req;
`endif
   assign last_cnt = cnt == CW'(WAIT_CYCLES - 1);
   assign busy = state != IDLE;
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   // next-state: one access lasts IDLE -> WAIT_CYCLES x ACCESS -> DONE
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE   ? ((m0_req | m1_req) ? ACCESS : IDLE) :
                 state == ACCESS ? (last_cnt ? DONE : ACCESS) : IDLE;
   end
   // datapath: latch the winner, hold ram inputs, capture read data and pulse done
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt              <= '0;
         sel              <= 1'b0;
         grant            <= 2'b00;
         ram_address      <= '0;
         ram_data_in      <= '0;
         ram_write_enable <= 1'b0;
         m0_rdata         <= '0;
         m1_rdata         <= '0;
         m0_done          <= 1'b0;
         m1_done          <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         ptr              <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (m0_req | m1_req) begin
                  sel              <= win;
                  grant            <= win ? 2'b10 : 2'b01;
                  ram_write_enable <= win ? m1_we : m0_we;
                  ram_address      <= win ? m1_addr : m0_addr;
                  ram_data_in      <= win ? m1_wdata : m0_wdata;
               end
            end
            ACCESS: begin
               cnt <= cnt + 1'b1;
               if (last_cnt) begin
                  ram_write_enable <= 1'b0;
                  m0_done          <= ~sel;
                  m1_done          <= sel;
                  if (!ram_write_enable && !sel) m0_rdata <= ram_data_out;
                  if (!ram_write_enable && sel) m1_rdata <= ram_data_out;
               end
            end
            DONE: begin
               m0_done <= 1'b0;
               m1_done <= 1'b0;
               grant   <= 2'b00;
`ifdef RAM_ARB_ROUND_ROBIN_EN
               ptr     <= ~sel;
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with behavioural ram models
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [15:0] m0_addr = 0, m1_addr = 0;
   logic [7:0] m0_wdata = 0, m1_wdata = 0;
   logic [7:0] m0_rdata, m1_rdata, ram_data_in, ram_data_out;
   logic m0_done, m1_done, busy, ram_write_enable;
   logic [1:0] grant;
   logic [15:0] ram_address;
   logic [7:0] mem [0:65535] = '{default: 8'h00};
   logic b_req = 0, b_we = 0;
   logic [15:0] b_addr = 0;
   logic [7:0] b_wdata = 0;
   logic [7:0] b_rdata0, b_rdata1, b_din, b_dout;
   logic b_done0, b_done1, b_busy, b_wen;
   logic [1:0] b_grant;
   logic [15:0] b_address;
   logic [7:0] b_mem [0:65535] = '{default: 8'h00};
   int errors = 0;
   int checks = 0;
   int n;
   always #5 clk = ~clk;
   ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_done(m0_done),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_done(m1_done),
      .grant(grant), .busy(busy), .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out));
   ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset(reset),
      .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr), .m0_wdata(b_wdata),
      .m0_rdata(b_rdata0), .m0_done(b_done0),
      .m1_req(1'b0), .m1_we(1'b0), .m1_addr(16'h0000), .m1_wdata(8'h00),
      .m1_rdata(b_rdata1), .m1_done(b_done1),
      .grant(b_grant), .busy(b_busy), .ram_address(b_address), .ram_data_in(b_din),
      .ram_write_enable(b_wen), .ram_data_out(b_dout));
   assign ram_data_out = mem[ram_address];
   assign b_dout = b_mem[b_address];
   // ram models: asynchronous read, write on rising edge
   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      if (b_wen) b_mem[b_address] <= b_din;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int k = 1);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_we", ram_write_enable, 0);
      check("rst_addr", ram_address, 0);
      check("rst_done", {m0_done, m1_done}, 0);
      check("rst_rdata", {m0_rdata, m1_rdata}, 0);
      reset = 0;
      m0_req = 1; m0_we = 1; m0_addr = 16'h1234; m0_wdata = 8'hA5;
      tick();
      check("t1_we_c1", ram_write_enable, 1);
      check("t1_grant", grant, 2'b01);
      check("t1_busy", busy, 1);
      check("t1_addr", ram_address, 16'h1234);
      check("t1_din", ram_data_in, 8'hA5);
      tick();
      check("t1_we_c2", ram_write_enable, 1);
      check("t1_nodone_c2", m0_done, 0);
      tick();
      check("t1_done_c3", m0_done, 1);
      check("t1_we_c3", ram_write_enable, 0);
      check("t1_addr_hold", ram_address, 16'h1234);
      m0_we = 0;
      tick();
      check("t1_done_once", m0_done, 0);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_grant", grant, 0);
      tick(3);
      check("t1_rd_done", m0_done, 1);
      check("t1_rd_data", m0_rdata, 8'hA5);
      m0_req = 0;
      tick();
      m1_req = 1; m1_we = 1; m1_addr = 16'hFFFF; m1_wdata = 8'h3C;
      tick();
      check("t3_grant", grant, 2'b10);
      check("t3_addr", ram_address, 16'hFFFF);
      tick(2);
      check("t3_wr_done", m1_done, 1);
      m1_we = 0;
      tick(4);
      check("t3_rd_done", m1_done, 1);
      check("t3_rd_data", m1_rdata, 8'h3C);
      check("t3_m0_keep", m0_rdata, 8'hA5);
      m1_req = 0;
      tick();
      m1_req = 1; m1_we = 0; m1_addr = 16'h1234;
      tick();
      check("t5_grant", grant, 2'b10);
      m1_req = 0; m1_addr = 16'hFFFF;
      n = 0;
      repeat (8) begin
         tick();
         n += int'(m1_done);
      end
      check("t5_one_done", n, 1);
      check("t5_rdata", m1_rdata, 8'hA5);
      check("t5_idle", busy, 0);
      m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 8'h77;
      tick();
      check("t4_access", busy, 1);
      reset = 1; m0_req = 0;
      tick();
      check("t4_busy", busy, 0);
      check("t4_grant", grant, 0);
      check("t4_we", ram_write_enable, 0);
      check("t4_done", m0_done, 0);
      reset = 0;
      n = 0;
      repeat (4) begin
         tick();
         n += int'(m0_done);
      end
      check("t4_no_done", n, 0);
      reset = 1;
      m0_req = 1; m0_we = 0; m0_addr = 16'h0001;
      m1_req = 1; m1_we = 0; m1_addr = 16'h0002;
      tick();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
`ifdef RAM_ARB_ROUND_ROBIN_EN
         check($sformatf("t2_grant%0d", i), grant, (i % 2) ? 2'b10 : 2'b01);
         tick(2);
         check($sformatf("t2_done%0d", i), {m1_done, m0_done}, (i % 2) ? 2'b10 : 2'b01);
`else
         check($sformatf("t2_grant%0d", i), grant, 2'b01);
         tick(2);
         check($sformatf("t2_done%0d", i), {m1_done, m0_done}, 2'b01);
`endif
         tick();
      end
      m0_req = 0; m1_req = 0;
      tick(4);
      b_req = 1; b_we = 1; b_addr = 16'h0005; b_wdata = 8'h5A;
      tick(2);
      check("t6_wr_done", b_done0, 1);
      b_we = 0;
      tick(3);
      check("t6_rd5_done", b_done0, 1);
      check("t6_rd5_data", b_rdata0, 8'h5A);
      b_addr = 16'h0000;
      tick(2);
      check("t6_c1_nodone", b_done0, 0);
      tick();
      check("t6_c2_done", b_done0, 1);
      check("t6_rd0_data", b_rdata0, 8'h00);
      b_req = 0;
      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
